// File: rtl/rdback_pkg.sv
// rdback_pkg: shared state type and widths for the readback credit controller
package rdback_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;
    localparam int CNT_W     = 11;
    localparam int TIMEOUT_W = 10;
endpackage

// File: rtl/rdback_updown_cnt.sv
// rdback_updown_cnt: saturating up/down counter with saturation and underflow flags
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : count up one
//   i_dec      : count down one (inc+dec together leaves the count unchanged)
//   o_cnt      : current count, 0..MAX
//   o_sat      : lone increment attempted while already at MAX (count holds)
//   o_unf      : lone decrement attempted while at 0 (count holds)
module rdback_updown_cnt #(
    parameter int W   = 11,
    parameter int MAX = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_sat,
    output logic         o_unf
);
    logic [W-1:0] r_cnt;
    logic         w_up;
    logic         w_dn;

    assign o_sat = i_inc & ~i_dec & (r_cnt == W'(MAX));
    assign o_unf = i_dec & ~i_inc & (r_cnt == '0);
    assign w_up  = i_inc & ~i_dec & ~o_sat;
    assign w_dn  = i_dec & ~i_inc & ~o_unf;
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_cnt <= '0;
        else if (w_up) r_cnt <= r_cnt + 1'b1;
        else if (w_dn) r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/rdback_credit_ctrl.sv
// rdback_credit_ctrl: credit-based admission control for DDR READs into the readback FIFO
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_enable          : level, allows grants
//   i_rd_req          : dispatcher wants to issue one READ
//   o_rd_grant        : READ may issue this cycle (zero latency)
//   o_rd_stall        : request present but not granted
//   i_rd_ret_valid    : one burst written into the FIFO
//   i_fifo_rden       : consumer pops one FIFO entry
//   i_flush_req       : pulse, stop granting and drain outstanding READs
//   o_flush_done      : one-cycle pulse when a requested drain completes
//   i_clr_err         : pulse, clears sticky errors and leaves ERR
//   o_inflight        : READs outstanding
//   o_occupancy       : FIFO entries held
//   o_err_timeout/overflow/underflow : sticky error flags
//   o_busy            : not idle or READs still outstanding
module rdback_credit_ctrl
    import rdback_pkg::*;
#(
    parameter int FIFO_DEPTH   = 1024,
    parameter int MAX_INFLIGHT = 16,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_rd_req,
    output logic             o_rd_grant,
    output logic             o_rd_stall,
    input  logic             i_rd_ret_valid,
    input  logic             i_fifo_rden,
    input  logic             i_flush_req,
    output logic             o_flush_done,
    input  logic             i_clr_err,
    output logic [CNT_W-1:0] o_inflight,
    output logic [CNT_W-1:0] o_occupancy,
    output logic             o_err_timeout,
    output logic             o_err_overflow,
    output logic             o_err_underflow,
    output logic             o_busy
);
    localparam logic [CNT_W:0] L_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_by_flush;
    logic                 w_by_flush_nxt;
    logic                 r_flush_done;
    logic                 w_flush_done_nxt;
    logic                 r_err_to;
    logic                 r_err_ov;
    logic                 r_err_un;
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic                 w_to_clr;
    logic                 w_to_hit;
    logic                 w_if_sat;
    logic                 w_if_unf;
    logic                 w_oc_sat;
    logic                 w_oc_unf;
    logic                 w_ev_ov;
    logic                 w_err_set;
    logic [CNT_W:0]       w_used;

    rdback_updown_cnt #(.W(CNT_W), .MAX(MAX_INFLIGHT)) u_inflight (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (o_rd_grant),
        .i_dec (i_rd_ret_valid),
        .o_cnt (o_inflight),
        .o_sat (w_if_sat),
        .o_unf (w_if_unf)
    );

    rdback_updown_cnt #(.W(CNT_W), .MAX(FIFO_DEPTH)) u_occupancy (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (i_rd_ret_valid),
        .i_dec (i_fifo_rden),
        .o_cnt (o_occupancy),
        .o_sat (w_oc_sat),
        .o_unf (w_oc_unf)
    );

    // free > 0 is equivalent to occupancy + inflight < depth, which cannot go negative
    assign w_used     = {1'b0, o_occupancy} + {1'b0, o_inflight};
    assign o_rd_grant = (r_state == RUN) & i_rd_req & (o_inflight < CNT_W'(MAX_INFLIGHT)) & (w_used < L_DEPTH);
    assign o_rd_stall = i_rd_req & ~o_rd_grant;
    assign o_busy     = (r_state != IDLE) | (o_inflight != '0);
    assign o_flush_done    = r_flush_done;
    assign o_err_timeout   = r_err_to;
    assign o_err_overflow  = r_err_ov;
    assign o_err_underflow = r_err_un;

    // A return with nothing outstanding is an overflow of the credit scheme
    assign w_ev_ov   = w_if_unf | w_if_sat | w_oc_sat;
    assign w_to_clr  = i_rd_ret_valid | (o_inflight == '0);
    assign w_to_hit  = ~w_to_clr & (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
    assign w_err_set = w_to_hit | w_ev_ov | w_oc_unf;

    always_comb begin
        w_state_nxt      = r_state;
        w_by_flush_nxt   = r_by_flush;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_flush_done_nxt = i_flush_req & (o_inflight == '0);
                if (i_flush_req && o_inflight != '0) begin
                    w_state_nxt    = DRAIN;
                    w_by_flush_nxt = 1'b1;
                end else if (i_enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_flush_req) begin
                    w_state_nxt    = DRAIN;
                    w_by_flush_nxt = 1'b1;
                end else if (!i_enable) begin
                    w_state_nxt    = DRAIN;
                    w_by_flush_nxt = 1'b0;
                end
            end
            DRAIN: begin
                w_by_flush_nxt = r_by_flush | i_flush_req;
                if (o_inflight == '0) begin
                    w_state_nxt      = i_enable ? RUN : IDLE;
                    w_flush_done_nxt = r_by_flush;
                    w_by_flush_nxt   = 1'b0;
                end
            end
            ERR: begin
                w_by_flush_nxt = 1'b0;
                if (i_clr_err && !w_err_set) w_state_nxt = IDLE;
            end
        endcase
        if (r_state != ERR && w_err_set) begin
            w_state_nxt      = ERR;
            w_by_flush_nxt   = 1'b0;
            w_flush_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_by_flush   <= 1'b0;
            r_flush_done <= 1'b0;
            r_err_to     <= 1'b0;
            r_err_ov     <= 1'b0;
            r_err_un     <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_by_flush   <= w_by_flush_nxt;
            r_flush_done <= w_flush_done_nxt;
            r_err_to     <= (r_err_to & ~i_clr_err) | w_to_hit;
            r_err_ov     <= (r_err_ov & ~i_clr_err) | w_ev_ov;
            r_err_un     <= (r_err_un & ~i_clr_err) | w_oc_unf;
            // Wraps on expiry so a still-stuck read times out again after clr_err
            r_to_cnt     <= (w_to_clr | w_to_hit) ? '0 : r_to_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rdback_credit_ctrl.sv
// tb_rdback_credit_ctrl: directed self-checking bench for the readback credit controller
module tb_rdback_credit_ctrl;
    import rdback_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, rd_req = 1'b0, ret = 1'b0, rden = 1'b0, flush = 1'b0, clr = 1'b0, b8_ret = 1'b0;
    logic grant, stall, done, e_to, e_ov, e_un, busy;
    logic [CNT_W-1:0] inflight, occ;
    logic g8, s8, d8, t8, o8, u8, b8;
    logic [CNT_W-1:0] if8, oc8;
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    rdback_credit_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_rd_req(rd_req),
        .o_rd_grant(grant), .o_rd_stall(stall), .i_rd_ret_valid(ret), .i_fifo_rden(rden),
        .i_flush_req(flush), .o_flush_done(done), .i_clr_err(clr),
        .o_inflight(inflight), .o_occupancy(occ), .o_err_timeout(e_to),
        .o_err_overflow(e_ov), .o_err_underflow(e_un), .o_busy(busy)
    );

    rdback_credit_ctrl #(.FIFO_DEPTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_rd_req(rd_req),
        .o_rd_grant(g8), .o_rd_stall(s8), .i_rd_ret_valid(b8_ret), .i_fifo_rden(1'b0),
        .i_flush_req(1'b0), .o_flush_done(d8), .i_clr_err(1'b0),
        .o_inflight(if8), .o_occupancy(oc8), .o_err_timeout(t8),
        .o_err_overflow(o8), .o_err_underflow(u8), .o_busy(b8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {enable, rd_req, ret, rden, flush, clr, b8_ret} = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic start_run();
        do_reset();
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        {enable, rd_req, ret, rden, flush, clr, b8_ret} = '0;
        rst_n = 1'b0;
        tick();
        total++;
        if ({grant, stall, done, e_to, e_ov, e_un, busy} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0000000", {grant, stall, done, e_to, e_ov, e_un, busy});
        else pass_cnt++;
        total++;
        if (inflight !== 11'd0) $display("FAIL reset_inflight: got %0d expected 0", inflight);
        else pass_cnt++;
        total++;
        if (occ !== 11'd0) $display("FAIL reset_occupancy: got %0d expected 0", occ);
        else pass_cnt++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_credit_limit();
        int n = 0;
        start_run();
        rd_req = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            n += int'(grant);
            tick();
        end
        total++;
        if (n != 16) $display("FAIL credit_grants: got %0d expected 16", n);
        else pass_cnt++;
        total++;
        if (stall !== 1'b1) $display("FAIL credit_stall: got %b expected 1", stall);
        else pass_cnt++;
        total++;
        if (inflight !== 11'd16) $display("FAIL credit_inflight: got %0d expected 16", inflight);
        else pass_cnt++;
        total++;
        if (busy !== 1'b1) $display("FAIL credit_busy: got %b expected 1", busy);
        else pass_cnt++;
        rd_req = 1'b0;
    endtask

    task automatic test_fifo_limit();
        int n = 0;
        logic g;
        start_run();
        rd_req = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            g = g8;
            n += int'(g);
            tick();
            b8_ret = g;
        end
        b8_ret = 1'b0;
        rd_req = 1'b0;
        tick();
        total++;
        if (n != 8) $display("FAIL fifo_grants: got %0d expected 8", n);
        else pass_cnt++;
        total++;
        if (oc8 !== 11'd8) $display("FAIL fifo_occupancy: got %0d expected 8", oc8);
        else pass_cnt++;
        total++;
        if (if8 !== 11'd0) $display("FAIL fifo_inflight: got %0d expected 0", if8);
        else pass_cnt++;
        total++;
        if ({t8, o8, u8} !== 3'b000) $display("FAIL fifo_errors: got %b expected 000", {t8, o8, u8});
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        start_run();
        rd_req = 1'b1;
        tick();
        ret = 1'b1;
        #1;
        total++;
        if (grant !== 1'b1) $display("FAIL same_grant: got %b expected 1", grant);
        else pass_cnt++;
        tick();
        total++;
        if (inflight !== 11'd1) $display("FAIL same_inflight: got %0d expected 1", inflight);
        else pass_cnt++;
        total++;
        if (occ !== 11'd1) $display("FAIL same_occ1: got %0d expected 1", occ);
        else pass_cnt++;
        rd_req = 1'b0;
        rden = 1'b1;
        tick();
        ret = 1'b0;
        rden = 1'b0;
        total++;
        if (inflight !== 11'd0) $display("FAIL same_inflight0: got %0d expected 0", inflight);
        else pass_cnt++;
        total++;
        if (occ !== 11'd1) $display("FAIL same_occ_hold: got %0d expected 1", occ);
        else pass_cnt++;
        total++;
        if ({e_to, e_ov, e_un} !== 3'b000) $display("FAIL same_errors: got %b expected 000", {e_to, e_ov, e_un});
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int drain_grants = 0;
        int done_cnt = 0;
        int done_at = -1;
        logic run_grant = 1'b0;
        start_run();
        rd_req = 1'b1;
        repeat (4) tick();
        rd_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rd_req = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drain_grants += int'(grant);
            if (i == 5) run_grant = grant;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            ret = (i < 4);
            tick();
        end
        ret = 1'b0;
        rd_req = 1'b0;
        total++;
        if (drain_grants != 0) $display("FAIL flush_no_grant: got %0d expected 0", drain_grants);
        else pass_cnt++;
        total++;
        if (done_cnt != 1) $display("FAIL flush_done_count: got %0d expected 1", done_cnt);
        else pass_cnt++;
        total++;
        if (done_at != 5) $display("FAIL flush_done_cycle: got %0d expected 5", done_at);
        else pass_cnt++;
        total++;
        if (run_grant !== 1'b1) $display("FAIL flush_back_to_run: got %b expected 1", run_grant);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        start_run();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (1022) tick();
        total++;
        if (e_to !== 1'b0) $display("FAIL timeout_early: got %b expected 0", e_to);
        else pass_cnt++;
        tick();
        total++;
        if (e_to !== 1'b1) $display("FAIL timeout_set: got %b expected 1", e_to);
        else pass_cnt++;
        rd_req = 1'b1;
        #1;
        total++;
        if (grant !== 1'b0) $display("FAIL timeout_no_grant: got %b expected 0", grant);
        else pass_cnt++;
        rd_req = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if ({e_to, e_ov, e_un} !== 3'b000) $display("FAIL timeout_clr: got %b expected 000", {e_to, e_ov, e_un});
        else pass_cnt++;
        total++;
        if (u_dut.r_state !== IDLE) $display("FAIL timeout_idle: got %0d expected %0d", u_dut.r_state, IDLE);
        else pass_cnt++;
    endtask

    task automatic test_underflow_reset();
        do_reset();
        rden = 1'b1;
        tick();
        rden = 1'b0;
        total++;
        if (e_un !== 1'b1) $display("FAIL underflow_flag: got %b expected 1", e_un);
        else pass_cnt++;
        total++;
        if (occ !== 11'd0) $display("FAIL underflow_occ: got %0d expected 0", occ);
        else pass_cnt++;
        start_run();
        rd_req = 1'b1;
        repeat (3) tick();
        total++;
        if (inflight !== 11'd3) $display("FAIL midrun_inflight: got %0d expected 3", inflight);
        else pass_cnt++;
        rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({grant, stall, done, e_to, e_ov, e_un, busy} !== 7'b0)
            $display("FAIL async_reset_flags: got %b expected 0000000", {grant, stall, done, e_to, e_ov, e_un, busy});
        else pass_cnt++;
        total++;
        if (inflight !== 11'd0 || occ !== 11'd0)
            $display("FAIL async_reset_counts: got %0d/%0d expected 0/0", inflight, occ);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_credit_limit();
        test_fifo_limit();
        test_same_cycle();
        test_flush();
        test_timeout();
        test_underflow_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
